health_bar: RTL and testbench

//  Parametrised N-box health bar with game-side state.

---
 rtl/health_pkg.sv | 15 +
 rtl/health_bar_box.sv | 20 ++
 rtl/health_bar.sv | 142 ++++++++++++++
 tb/tb_health_bar.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/health_pkg.sv
// Shared types and helpers for the health bar: FSM state encoding and counter sizing.
package health_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    DEAD  = 2'd2
  } health_state_t;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/health_bar_box.sv
// Pixel hit test for a single square health box anchored at (pos_x_i, pos_y_i).
module health_bar_box #(
  parameter int unsigned BOX_SIZE = 16
) (
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic [9:0] pos_x_i,
  input  logic [9:0] pos_y_i,
  output logic       hit_c_o
);

  logic [9:0] dx;
  logic [9:0] dy;

  // Modular offsets keep the test correct when a box straddles the 1024 wrap.
  assign dx      = draw_x_i - pos_x_i;
  assign dy      = draw_y_i - pos_y_i;
  assign hit_c_o = (dx < 10'(BOX_SIZE)) && (dy < 10'(BOX_SIZE));

endmodule

// File: rtl/health_bar.sv
// N-box health bar: health count FSM with post-hit blink/invulnerability and
// per-box pixel gating for the colour mapper.
module health_bar
  import health_pkg::*;
#(
  parameter int unsigned NUM_BOXES    = 5,
  parameter int unsigned BOX_SIZE     = 16,
  parameter int unsigned OFFSET       = 4,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned BLINK_HALF   = 4,
  localparam int unsigned CW          = count_width(NUM_BOXES)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [9:0]           Health_Pos_X,
  input  logic [9:0]           Health_Pos_Y,
  input  logic                 damage,
  input  logic                 heal,
  input  logic                 restore,
  output logic [NUM_BOXES-1:0] is_health,
  output logic [CW-1:0]        health_count,
  output logic                 invuln,
  output logic                 is_dead
);

  localparam int unsigned FW    = $clog2(BLINK_FRAMES);
  localparam int unsigned PITCH = BOX_SIZE + OFFSET;

  health_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] blink_idx_q, blink_idx_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          frame_q;

  logic frame_tick_c;
  logic half_end_c;
  logic last_frame_c;
  logic blink_on_c;

  assign frame_tick_c = frame_clk & ~frame_q;
  assign half_end_c   = (32'(frame_cnt_q) % BLINK_HALF) == (BLINK_HALF - 1);
  assign last_frame_c = frame_cnt_q == FW'(BLINK_FRAMES - 1);
  assign blink_on_c   = (state_q == HIT) & blink_phase_q;

  // Next-state logic; restore overrides everything, damage beats heal.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    blink_idx_d   = blink_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;

    if (restore) begin
      state_d       = ALIVE;
      count_d       = CW'(NUM_BOXES);
      blink_idx_d   = '0;
      frame_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else begin
      case (state_q)
        ALIVE: begin
          if (damage) begin
            count_d       = count_q - CW'(1);
            blink_idx_d   = count_q - CW'(1);
            frame_cnt_d   = '0;
            blink_phase_d = 1'b1;
            state_d       = HIT;
          end else if (heal && (count_q < CW'(NUM_BOXES))) begin
            count_d = count_q + CW'(1);
          end
        end
        HIT: begin
          if (frame_tick_c) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
            if (half_end_c) begin
              blink_phase_d = ~blink_phase_q;
            end
            if (last_frame_c) begin
              frame_cnt_d   = '0;
              blink_phase_d = 1'b0;
              state_d       = (count_q == '0) ? DEAD : ALIVE;
            end
          end
        end
        DEAD: begin
          state_d = DEAD;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ALIVE;
      count_q       <= CW'(NUM_BOXES);
      blink_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      blink_idx_q   <= blink_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_q       <= frame_clk;
    end
  end

  assign health_count = count_q;
  assign invuln       = (state_q == HIT);
  assign is_dead      = (state_q == DEAD);

  // A box is lit while it is still owned, or while it is the blinking lost box.
  for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
    logic [9:0] pos_x;
    logic       hit;

    assign pos_x = Health_Pos_X + 10'(i * PITCH);

    health_bar_box #(
      .BOX_SIZE(BOX_SIZE)
    ) u_box (
      .draw_x_i(DrawX),
      .draw_y_i(DrawY),
      .pos_x_i (pos_x),
      .pos_y_i (Health_Pos_Y),
      .hit_c_o (hit)
    );

    assign is_health[i] = hit & ((CW'(i) < count_q) |
                                 (blink_on_c & (blink_idx_q == CW'(i))));
  end

endmodule

// File: tb/tb_health_bar.sv
// Randomised self-checking bench for health_bar against a frame-counting model.
module tb_health_bar;

  localparam int NB      = 5;
  localparam int POS_X   = 100;
  localparam int POS_Y   = 20;
  localparam int PITCH   = 20;
  localparam int BOX     = 16;
  localparam int FRAMES  = 32;
  localparam int HALF    = 4;
  localparam int S_ALIVE = 0;
  localparam int S_HIT   = 1;
  localparam int S_DEAD  = 2;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] Health_Pos_X;
  logic [9:0] Health_Pos_Y;
  logic       damage;
  logic       heal;
  logic       restore;
  logic [4:0] is_health;
  logic [2:0] health_count;
  logic       invuln;
  logic       is_dead;

  int checks;
  int errors;

  // Model: health, mode, ticks seen since the last hit, and the lost box.
  int m_count;
  int m_state;
  int m_ticks;
  int m_idx;
  bit m_fprev;

  health_bar dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .Health_Pos_X(Health_Pos_X),
    .Health_Pos_Y(Health_Pos_Y),
    .damage      (damage),
    .heal        (heal),
    .restore     (restore),
    .is_health   (is_health),
    .health_count(health_count),
    .invuln      (invuln),
    .is_dead     (is_dead)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void model_reset();
    m_count = NB;
    m_state = S_ALIVE;
    m_ticks = 0;
    m_idx   = 0;
    m_fprev = 1'b0;
  endfunction

  function automatic void model_step(input bit d, input bit h, input bit r, input bit f);
    bit tick;
    tick    = f && !m_fprev;
    m_fprev = f;
    if (r) begin
      m_count = NB;
      m_state = S_ALIVE;
      m_ticks = 0;
    end else if (m_state == S_ALIVE) begin
      if (d) begin
        m_idx   = m_count - 1;
        m_count = m_count - 1;
        m_ticks = 0;
        m_state = S_HIT;
      end else if (h && m_count < NB) begin
        m_count = m_count + 1;
      end
    end else if (m_state == S_HIT && tick) begin
      m_ticks = m_ticks + 1;
      if (m_ticks == FRAMES) m_state = (m_count == 0) ? S_DEAD : S_ALIVE;
    end
  endfunction

  // Expected pixel vector: box geometry by plain integer ranges, blink lit on even half-periods.
  function automatic logic [4:0] exp_pix(input int x, input int y);
    logic [4:0] v;
    int px;
    bit inbox;
    bit lit;
    v = '0;
    for (int i = 0; i < NB; i++) begin
      px    = POS_X + i * PITCH;
      inbox = (x >= px) && (x < px + BOX) && (y >= POS_Y) && (y < POS_Y + BOX);
      lit   = (i < m_count) ||
              (m_state == S_HIT && i == m_idx && ((m_ticks / HALF) % 2 == 0));
      v[i]  = inbox && lit;
    end
    return v;
  endfunction

  task automatic cycle(input bit d, input bit h, input bit r, input bit f);
    damage    = d;
    heal      = h;
    restore   = r;
    frame_clk = f;
    @(posedge Clk);
    model_step(d, h, r, f);
    #1;
    damage  = 1'b0;
    heal    = 1'b0;
    restore = 1'b0;
  endtask

  task automatic finish_blink();
    int n;
    n = 0;
    while (m_state == S_HIT && n < 2000) begin
      cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    checks++;
    if (invuln !== 1'b0) begin
      errors++;
      $display("FAIL blink_done: invuln=%b want 0 after %0d cycles", invuln, n);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    checks++;
    if (health_count !== 3'd5 || invuln !== 1'b0 || is_dead !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d inv=%b dead=%b want 5 0 0", health_count, invuln, is_dead);
    end
    checks++;
    if (is_health !== 5'b10000) begin
      errors++;
      $display("FAIL reset_pix: pix=%b want 10000", is_health);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_damage_blink();
    int n;
    DrawX = 10'd185;
    DrawY = 10'd25;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (health_count !== 3'd4 || invuln !== 1'b1 || is_health !== 5'b10000) begin
      errors++;
      $display("FAIL dmg_accept: count=%0d inv=%b pix=%b want 4 1 10000", health_count, invuln, is_health);
    end
    n = 0;
    while (m_state == S_HIT && n < 1000) begin
      // Stray damage/heal during the blink must be ignored.
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b0,
            1'($urandom_range(0, 1)));
      checks++;
      if (health_count !== 3'(m_count) || invuln !== (m_state == S_HIT) ||
          is_dead !== (m_state == S_DEAD) || is_health !== exp_pix(DrawX, DrawY)) begin
        errors++;
        $display("FAIL blink: count=%0d inv=%b dead=%b pix=%b want count=%0d st=%0d pix=%b ticks=%0d",
                 health_count, invuln, is_dead, is_health, m_count, m_state,
                 exp_pix(DrawX, DrawY), m_ticks);
      end
      n++;
    end
    checks++;
    if (health_count !== 3'd4 || invuln !== 1'b0 || is_health[4] !== 1'b0) begin
      errors++;
      $display("FAIL blink_end: count=%0d inv=%b box4=%b want 4 0 0", health_count, invuln, is_health[4]);
    end
  endtask

  task automatic test_heal();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (health_count !== 3'd5) begin
      errors++;
      $display("FAIL heal_up: count=%0d want 5", health_count);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (health_count !== 3'd5 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL heal_sat: count=%0d inv=%b want 5 0", health_count, invuln);
    end
  endtask

  task automatic test_dmg_heal_same();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      finish_blink();
    end
    checks++;
    if (health_count !== 3'd3) begin
      errors++;
      $display("FAIL pre_same: count=%0d want 3", health_count);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (health_count !== 3'd2 || invuln !== 1'b1) begin
      errors++;
      $display("FAIL dmg_heal_same: count=%0d inv=%b want 2 1", health_count, invuln);
    end
    finish_blink();
  endtask

  task automatic test_dead();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NB; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      finish_blink();
    end
    checks++;
    if (health_count !== 3'd0 || is_dead !== 1'b1 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL dead: count=%0d dead=%b inv=%b want 0 1 0", health_count, is_dead, invuln);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'(k % 2 == 0), 1'(k % 2 == 1), 1'b0, 1'(k % 2));
      checks++;
      if (health_count !== 3'd0 || is_dead !== 1'b1) begin
        errors++;
        $display("FAIL dead_hold: count=%0d dead=%b want 0 1", health_count, is_dead);
      end
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (health_count !== 3'd5 || is_dead !== 1'b0 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL restore: count=%0d dead=%b inv=%b want 5 0 0", health_count, is_dead, invuln);
    end
  endtask

  task automatic test_geometry();
    logic [9:0] xs [6];
    logic [9:0] ys [6];
    bit         want [6];
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int x = 115; x <= 141; x++) begin
      for (int y = 17; y <= 38; y++) begin
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
        checks++;
        if (is_health !== exp_pix(x, y)) begin
          errors++;
          $display("FAIL sweep x=%0d y=%0d: pix=%b want %b", x, y, is_health, exp_pix(x, y));
        end
      end
    end
    xs = '{10'd120, 10'd135, 10'd136, 10'd119, 10'd120, 10'd120};
    ys = '{10'd20, 10'd35, 10'd20, 10'd20, 10'd36, 10'd19};
    want = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      DrawX = xs[k];
      DrawY = ys[k];
      #1;
      checks++;
      if (is_health[1] !== want[k]) begin
        errors++;
        $display("FAIL box1_edge x=%0d y=%0d: hit=%b want %b", xs[k], ys[k], is_health[1], want[k]);
      end
    end
  endtask

  task automatic test_reset_mid_hit();
    DrawX = 10'd185;
    DrawY = 10'd25;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0, 1'(k % 2));
    frame_clk = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (health_count !== 3'd5 || invuln !== 1'b0 || is_dead !== 1'b0 || is_health !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid_hit: count=%0d inv=%b dead=%b pix=%b want 5 0 0 10000",
               health_count, invuln, is_dead, is_health);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (health_count !== 3'd5 || invuln !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: count=%0d inv=%b want 5 0", health_count, invuln);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      DrawX = 10'($urandom_range(90, 210));
      DrawY = 10'($urandom_range(12, 42));
      cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)));
      checks++;
      if (health_count !== 3'(m_count) || invuln !== (m_state == S_HIT) ||
          is_dead !== (m_state == S_DEAD) || is_health !== exp_pix(DrawX, DrawY)) begin
        errors++;
        $display("FAIL random n=%0d: count=%0d inv=%b dead=%b pix=%b want count=%0d st=%0d pix=%b",
                 n, health_count, invuln, is_dead, is_health, m_count, m_state,
                 exp_pix(DrawX, DrawY));
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    frame_clk    = 1'b0;
    damage       = 1'b0;
    heal         = 1'b0;
    restore      = 1'b0;
    DrawX        = 10'd185;
    DrawY        = 10'd25;
    Health_Pos_X = 10'(POS_X);
    Health_Pos_Y = 10'(POS_Y);
    model_reset();

    test_reset();
    test_damage_blink();
    test_heal();
    test_dmg_heal_same();
    test_dead();
    test_geometry();
    test_reset_mid_hit();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
